// File: rtl/ysyx_22050019_icache_rsp_pkg.sv
// Shared definitions for the instruction-cache response block: FSM state
// encoding, AXI response codes, line/beat widths and the fixed burst shape.
package ysyx_22050019_icache_rsp_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MISS_AR = 3'd2,
    S_MISS_R  = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int LINE_W = 128;
  localparam int BEAT_W = 64;

  // A line is fetched as two 64-bit INCR beats.
  localparam logic [7:0] AR_LEN   = 8'd1;
  localparam logic [2:0] AR_SIZE  = 3'b011;
  localparam logic [1:0] AR_BURST = 2'b01;

endpackage

// File: rtl/ysyx_22050019_icache_rsp_array.sv
// Direct-mapped line storage: valid bits, tags and 128-bit data.
// Reads are combinational; writes and the clear-all happen on the clock edge.
module ysyx_22050019_icache_array
  import ysyx_22050019_icache_rsp_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int TAG_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic [$clog2(SETS)-1:0] i_rd_idx,
  output logic                    o_rd_valid,
  output logic [TAG_W-1:0]        o_rd_tag,
  output logic [LINE_W-1:0]       o_rd_data,
  input  logic                    i_wr_en,
  input  logic [$clog2(SETS)-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]        i_wr_tag,
  input  logic [LINE_W-1:0]       i_wr_data
);

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_data [SETS];

  // Valid bits: cleared by reset or a fence, set by a clean line fill.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/ysyx_22050019_icache_rsp.sv
// Blocking direct-mapped instruction cache returning whole 128-bit lines.
// One request in flight: AR accepted in IDLE, looked up, refilled from a
// two-beat downstream burst on a miss, then held in RESP until taken.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; a source holds valid and its payload stable until that edge.
module ysyx_22050019_icache_rsp
  import ysyx_22050019_icache_rsp_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ar_valid_i,
  output logic              ar_ready_o,
  input  logic [31:0]       ar_addr_i,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic [LINE_W-1:0] r_data_o,
  output logic [1:0]        r_resp_o,
  output logic              mem_ar_valid_o,
  input  logic              mem_ar_ready_i,
  output logic [31:0]       mem_ar_addr_o,
  output logic [7:0]        mem_ar_len_o,
  output logic [2:0]        mem_ar_size_o,
  output logic [1:0]        mem_ar_burst_o,
  input  logic              mem_r_valid_i,
  output logic              mem_r_ready_o,
  input  logic [BEAT_W-1:0] mem_r_data_i,
  input  logic [1:0]        mem_r_resp_i,
  input  logic              mem_r_last_i,
  input  logic              fence_i_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 28 - IDX_W;

  state_e            r_state;
  state_e            w_next_state;
  logic [27:0]       r_line_addr;
  logic [LINE_W-1:0] r_line;
  logic [1:0]        r_resp;
  logic              r_err;
  logic              r_beat;
  logic              r_fence_pending;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [LINE_W-1:0] w_rd_data;
  logic              w_hit;
  logic              w_ar_hs;
  logic              w_clr;
  logic              w_beat_acc;
  logic              w_beat_err;
  logic              w_err_final;
  logic              w_fill;
  logic              w_unused_offset;

  // The byte offset within a line never matters for a whole-line fetch.
  assign w_unused_offset = ^ar_addr_i[3:0];

  assign w_idx      = r_line_addr[IDX_W-1:0];
  assign w_tag      = r_line_addr[27:IDX_W];
  assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
  assign w_ar_hs    = ar_valid_i && ar_ready_o;
  // A fence seen in IDLE, or one deferred while busy, wipes the array here.
  assign w_clr      = (r_state == S_IDLE) && (fence_i_i || r_fence_pending);
  assign w_beat_acc = (r_state == S_MISS_R) && mem_r_valid_i;
  // Beat 0 must not carry LAST, beat 1 must; any non-OKAY beat also poisons.
  assign w_beat_err = (mem_r_resp_i != RESP_OKAY) ||
                      (r_beat ? !mem_r_last_i : mem_r_last_i);
  assign w_err_final = r_err || w_beat_err;
  assign w_fill      = w_beat_acc && r_beat && !w_err_final;

  ysyx_22050019_icache_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill),
    .i_wr_idx   (w_idx),
    .i_wr_tag   (w_tag),
    .i_wr_data  ({mem_r_data_i, r_line[BEAT_W-1:0]})
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_ar_hs) w_next_state = S_LOOKUP;
      S_LOOKUP:  w_next_state = w_hit ? S_RESP : S_MISS_AR;
      S_MISS_AR: if (mem_ar_ready_i) w_next_state = S_MISS_R;
      S_MISS_R:  if (w_beat_acc && r_beat) w_next_state = S_RESP;
      S_RESP:    if (r_ready_i) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Request address, response line, burst tracking and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line_addr <= '0;
      r_line      <= '0;
      r_resp      <= RESP_OKAY;
      r_err       <= 1'b0;
      r_beat      <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_line_addr <= ar_addr_i[31:4];
      end
      if (r_state == S_LOOKUP) begin
        r_err  <= 1'b0;
        r_beat <= 1'b0;
        if (w_hit) begin
          r_line    <= w_rd_data;
          r_resp    <= RESP_OKAY;
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end
      if (w_beat_acc) begin
        r_beat <= ~r_beat;
        r_err  <= w_err_final;
        if (!r_beat) begin
          r_line[BEAT_W-1:0] <= mem_r_data_i;
        end else begin
          r_line[LINE_W-1:BEAT_W] <= mem_r_data_i;
          r_resp <= w_err_final ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Fence arriving mid-request is remembered until the next IDLE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fence_pending <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_fence_pending <= 1'b0;
    end else if (fence_i_i) begin
      r_fence_pending <= 1'b1;
    end
  end

  assign ar_ready_o     = rst_n && (r_state == S_IDLE) && !r_fence_pending && !fence_i_i;
  assign r_valid_o      = (r_state == S_RESP);
  assign r_data_o       = r_valid_o ? r_line : '0;
  assign r_resp_o       = r_valid_o ? r_resp : RESP_OKAY;
  assign mem_ar_valid_o = (r_state == S_MISS_AR);
  assign mem_ar_addr_o  = mem_ar_valid_o ? {r_line_addr, 4'h0} : 32'h0;
  assign mem_ar_len_o   = AR_LEN;
  assign mem_ar_size_o  = AR_SIZE;
  assign mem_ar_burst_o = AR_BURST;
  assign mem_r_ready_o  = (r_state == S_MISS_R);
  assign hit_cnt_o      = r_hit_cnt;
  assign miss_cnt_o     = r_miss_cnt;

endmodule

// File: tb/tb_ysyx_22050019_icache_rsp.sv
// Bench for the icache response block: directed scenarios followed by
// random traffic, with expected responses queued by the driver and popped
// by an independent monitor on every upstream R handshake.
module tb_ysyx_22050019_icache_rsp;
  import ysyx_22050019_icache_rsp_pkg::*;

  localparam int SETS = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ar_valid_i = 1'b0;
  logic         ar_ready_o;
  logic [31:0]  ar_addr_i = '0;
  logic         r_valid_o;
  logic         r_ready_i = 1'b0;
  logic [127:0] r_data_o;
  logic [1:0]   r_resp_o;
  logic         mem_ar_valid_o;
  logic         mem_ar_ready_i = 1'b0;
  logic [31:0]  mem_ar_addr_o;
  logic [7:0]   mem_ar_len_o;
  logic [2:0]   mem_ar_size_o;
  logic [1:0]   mem_ar_burst_o;
  logic         mem_r_valid_i = 1'b0;
  logic         mem_r_ready_o;
  logic [63:0]  mem_r_data_i = '0;
  logic [1:0]   mem_r_resp_i = '0;
  logic         mem_r_last_i = 1'b0;
  logic         fence_i_i = 1'b0;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  int total = 0;
  int bad = 0;
  logic [129:0] exp_q[$];

  // Reference model: which line address each set currently holds.
  bit          mv[SETS];
  logic [27:0] ml[SETS];
  int unsigned hit_m = 0;
  int unsigned miss_m = 0;

  ysyx_22050019_icache_rsp #(.SETS(SETS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ar_valid_i     (ar_valid_i),
    .ar_ready_o     (ar_ready_o),
    .ar_addr_i      (ar_addr_i),
    .r_valid_o      (r_valid_o),
    .r_ready_i      (r_ready_i),
    .r_data_o       (r_data_o),
    .r_resp_o       (r_resp_o),
    .mem_ar_valid_o (mem_ar_valid_o),
    .mem_ar_ready_i (mem_ar_ready_i),
    .mem_ar_addr_o  (mem_ar_addr_o),
    .mem_ar_len_o   (mem_ar_len_o),
    .mem_ar_size_o  (mem_ar_size_o),
    .mem_ar_burst_o (mem_ar_burst_o),
    .mem_r_valid_i  (mem_r_valid_i),
    .mem_r_ready_o  (mem_r_ready_o),
    .mem_r_data_i   (mem_r_data_i),
    .mem_r_resp_i   (mem_r_resp_i),
    .mem_r_last_i   (mem_r_last_i),
    .fence_i_i      (fence_i_i),
    .hit_cnt_o      (hit_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Downstream memory contents: fixed pattern per line, with the line at
  // 0x8000_0000 holding the documented cold-miss data.
  function automatic logic [63:0] mem_beat(input logic [27:0] line, input bit b);
    if (line == 28'h800_0000) return b ? 64'h5555_6666_7777_8888 : 64'h1111_2222_3333_4444;
    return {line, 3'b101, b, ~line, 4'hC};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) mv[i] = 1'b0;
  endtask

  task automatic clear_inputs();
    ar_valid_i = 0; r_ready_i = 0; mem_ar_ready_i = 0; mem_r_valid_i = 0;
    mem_r_last_i = 0; mem_r_resp_i = 0; fence_i_i = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ar_ready"}, ar_ready_o, 0);
    check({name, "_r_valid"}, r_valid_o, 0);
    check({name, "_r_data"}, r_data_o, 0);
    check({name, "_r_resp"}, r_resp_o, 0);
    check({name, "_mem_ar_valid"}, mem_ar_valid_o, 0);
    check({name, "_mem_ar_addr"}, mem_ar_addr_o, 0);
    check({name, "_mem_r_ready"}, mem_r_ready_o, 0);
    check({name, "_hit_cnt"}, hit_cnt_o, 0);
    check({name, "_miss_cnt"}, miss_cnt_o, 0);
  endtask

  // Bring the DUT back to a known state after a lost handshake.
  task automatic recover();
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_clear();
    exp_q.delete();
    hit_m = 0; miss_m = 0;
  endtask

  task automatic timeout_fail(input string name, input int cycles);
    total++; bad++;
    $display("FAIL %s: no event after %0d cycles, required within budget", name, cycles);
    recover();
  endtask

  task automatic do_fence();
    @(negedge clk);
    fence_i_i = 1; ar_valid_i = 1; ar_addr_i = $urandom();
    #1 check("fence_blocks_ar", ar_ready_o, 0);
    @(negedge clk);
    fence_i_i = 0; ar_valid_i = 0;
    #1 check("ready_after_fence", ar_ready_o, 1);
    model_clear();
  endtask

  // err_kind: 0 clean, 1 SLVERR on beat 1, 2 SLVERR on beat 0,
  // 3 LAST on beat 0, 4 no LAST on beat 1.
  task automatic do_read(input logic [31:0] addr, input int err_kind, input bit fence_mid, input int rr_hold);
    logic [27:0]  line;
    logic [63:0]  b0, b1;
    logic [1:0]   exp_resp;
    logic [129:0] snap;
    bit hit, fenced;
    int idx, n;
    line = addr[31:4];
    idx = int'(line % SETS);
    hit = mv[idx] && (ml[idx] == line);
    fenced = fence_mid && !hit;
    b0 = mem_beat(line, 1'b0);
    b1 = mem_beat(line, 1'b1);
    exp_resp = (hit || err_kind == 0) ? RESP_OKAY : RESP_SLVERR;
    exp_q.push_back({exp_resp, b1, b0});
    if (hit) hit_m++;
    else begin
      miss_m++;
      if (err_kind == 0) begin mv[idx] = 1'b1; ml[idx] = line; end
      if (fenced) model_clear();
    end

    @(negedge clk);
    ar_valid_i = 1; ar_addr_i = addr;
    n = 0;
    while (!ar_ready_o && n < 20) begin @(negedge clk); n++; end
    if (!ar_ready_o) begin timeout_fail("ar_ready", n); return; end
    @(negedge clk);
    ar_valid_i = 0; ar_addr_i = $urandom();

    if (hit) begin
      check("hit_lookup_no_rvalid", r_valid_o, 0);
      @(negedge clk);
      check("hit_latency_rvalid", r_valid_o, 1);
      check("hit_no_mem_ar", mem_ar_valid_o, 0);
    end else begin
      n = 0;
      while (!mem_ar_valid_o && n < 10) begin @(negedge clk); n++; end
      if (!mem_ar_valid_o) begin timeout_fail("mem_ar_valid", n); return; end
      check("mem_ar_addr", mem_ar_addr_o, {addr[31:4], 4'h0});
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("mem_ar_stable", {mem_ar_valid_o, mem_ar_addr_o}, {1'b1, addr[31:4], 4'h0});
      end
      mem_ar_ready_i = 1;
      @(negedge clk);
      mem_ar_ready_i = 0;
      if (fenced) begin
        fence_i_i = 1;
        @(negedge clk);
        fence_i_i = 0;
      end
      for (int b = 0; b < 2; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("mem_r_ready", mem_r_ready_o, 1);
        mem_r_valid_i = 1;
        mem_r_data_i = (b == 0) ? b0 : b1;
        mem_r_resp_i = ((err_kind == 2 && b == 0) || (err_kind == 1 && b == 1)) ? 2'b10 : 2'b00;
        mem_r_last_i = (b == 0) ? (err_kind == 3) : (err_kind != 4);
        @(negedge clk);
        mem_r_valid_i = 0; mem_r_last_i = 0; mem_r_resp_i = 0;
      end
    end

    n = 0;
    while (!r_valid_o && n < 20) begin @(negedge clk); n++; end
    if (!r_valid_o) begin timeout_fail("r_valid", n); return; end
    snap = {r_resp_o, r_data_o};
    repeat (rr_hold) begin
      @(negedge clk);
      check("rsp_stable", {r_valid_o, r_resp_o, r_data_o}, {1'b1, snap});
    end
    r_ready_i = 1;
    @(negedge clk);
    r_ready_i = 0;
    check("hit_cnt", hit_cnt_o, hit_m);
    check("miss_cnt", miss_cnt_o, miss_m);
    #1 check("ar_ready_after_rsp", ar_ready_o, fenced ? 1'b0 : 1'b1);
  endtask

  // Reset arrives after the first refill beat; nothing is ever returned.
  task automatic do_reset_mid_miss(input logic [31:0] addr);
    int n;
    @(negedge clk);
    ar_valid_i = 1; ar_addr_i = addr;
    n = 0;
    while (!ar_ready_o && n < 20) begin @(negedge clk); n++; end
    if (!ar_ready_o) begin timeout_fail("rst_ar_ready", n); return; end
    @(negedge clk);
    ar_valid_i = 0;
    n = 0;
    while (!mem_ar_valid_o && n < 10) begin @(negedge clk); n++; end
    if (!mem_ar_valid_o) begin timeout_fail("rst_mem_ar_valid", n); return; end
    mem_ar_ready_i = 1;
    @(negedge clk);
    mem_ar_ready_i = 0;
    mem_r_valid_i = 1; mem_r_data_i = mem_beat(addr[31:4], 1'b0); mem_r_last_i = 0;
    @(negedge clk);
    check("rst_in_miss_r", mem_r_ready_o, 1);
    rst_n = 0;
    @(negedge clk);
    mem_r_valid_i = 0;
    #1 check_reset_outputs("mid_miss_rst");
    rst_n = 1;
    model_clear();
    hit_m = 0; miss_m = 0;
  endtask

  // Monitor: pops one expectation per R handshake; idle data must read zero.
  initial begin
    logic [129:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (r_valid_o !== 1'b1) begin
        check("rdata_zero_when_idle", r_data_o, 0);
      end else if (r_ready_i) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp actual=%0h required=no response", {r_resp_o, r_data_o});
        end else begin
          e = exp_q.pop_front();
          check("rsp", {r_resp_o, r_data_o}, e);
        end
      end
    end
  end

  // Stimulus and final report.
  initial begin
    logic [27:0] rl;
    model_clear();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("por");
    check("ar_len", mem_ar_len_o, 8'd1);
    check("ar_size", mem_ar_size_o, 3'b011);
    check("ar_burst", mem_ar_burst_o, 2'b01);
    rst_n = 1;
    @(negedge clk);
    check("idle_ready", ar_ready_o, 1);

    // Cold miss then hit on the same line.
    do_read(32'h8000_0004, 0, 0, 0);
    do_read(32'h8000_000C, 0, 0, 1);

    // Conflict eviction in set 0.
    do_fence();
    do_read(32'h8000_0000, 0, 0, 0);
    do_read(32'h8000_0100, 0, 0, 0);
    do_read(32'h8000_0000, 0, 0, 0);

    // Burst errors of each kind, each followed by a re-read that must miss.
    for (int k = 1; k <= 4; k++) begin
      do_read(32'h8000_0200 + (k << 10), k, 0, 0);
      do_read(32'h8000_0200 + (k << 10), 0, 0, 0);
      do_read(32'h8000_0204 + (k << 10), 0, 0, 0);
    end

    // Backpressure with a fence during the refill.
    do_read(32'h8000_0300, 0, 1, 5);
    do_read(32'h8000_0300, 0, 0, 0);

    // Reset in the middle of a refill drops previously cached lines.
    do_read(32'h8000_0400, 0, 0, 0);
    do_read(32'h8000_0408, 0, 0, 0);
    do_reset_mid_miss(32'h8000_0500);
    do_read(32'h8000_0400, 0, 0, 0);
    check("ar_len_late", mem_ar_len_o, 8'd1);

    // Random traffic over a small pool of lines to mix hits and conflicts.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_fence();
      end else begin
        rl = 28'h800_0000 + 28'($urandom_range(0, 47));
        do_read({rl, 4'($urandom_range(0, 15))},
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0,
                ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 3)));
      end
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
